// File: rtl/exc_sequencer.sv
// Exception entry/return sequencer: arbitrates IRQ lines and undefined-opcode faults,
// captures ELR/ESR, pulses the PC redirect and IRQ acknowledge, halts on a fault inside a handler.
module exc_sequencer #(
  parameter int N    = 64,
  parameter int NIRQ = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_req,
  input  logic            not_an_instr,
  input  logic            eret,
  input  logic [N-1:0]    pc_in,
  output logic            exc_take,
  output logic [NIRQ-1:0] irq_ack,
  output logic [2:0]      irq_id,
  output logic [N-1:0]    elr,
  output logic [3:0]      esr,
  output logic            in_handler,
  output logic            halted
);

  // state   | meaning
  // RUN     | normal execution, faults and IRQs accepted
  // TAKE    | one-cycle redirect to the exception vector
  // HANDLER | handler running, IRQs masked
  // HALT    | fault inside handler, stuck until reset
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    HALT    = 2'd3
  } state_t;

  localparam logic [3:0] ESR_IRQ    = 4'b0001;
  localparam logic [3:0] ESR_UNDEF  = 4'b0010;
  localparam logic [3:0] ESR_DOUBLE = 4'b1000;

  state_t          state, state_nxt;
  logic [NIRQ-1:0] ack_nxt, win_onehot;
  logic [2:0]      id_nxt, win_id;
  logic [N-1:0]    elr_nxt;
  logic [3:0]      esr_nxt;

  // Lowest set index wins: scan downward so the lowest index is assigned last.
  always_comb begin
    win_id     = '0;
    win_onehot = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (irq_req[i]) begin
        win_id        = 3'(i);
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ack_nxt   = '0;
    id_nxt    = irq_id;
    elr_nxt   = elr;
    esr_nxt   = esr;
    case (state)
      RUN: begin
        if (not_an_instr) begin
          state_nxt = TAKE;
          elr_nxt   = pc_in;
          esr_nxt   = ESR_UNDEF;
        end else if (|irq_req) begin
          state_nxt = TAKE;
          elr_nxt   = pc_in;
          esr_nxt   = ESR_IRQ;
          id_nxt    = win_id;
          ack_nxt   = win_onehot;
        end
      end
      TAKE: state_nxt = HANDLER;
      HANDLER: begin
        if (not_an_instr) begin
          state_nxt = HALT;
          esr_nxt   = ESR_DOUBLE;
        end else if (eret) begin
          state_nxt = RUN;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      irq_ack <= '0;
      irq_id  <= '0;
      elr     <= '0;
      esr     <= '0;
    end else begin
      state   <= state_nxt;
      irq_ack <= ack_nxt;
      irq_id  <= id_nxt;
      elr     <= elr_nxt;
      esr     <= esr_nxt;
    end
  end

  assign exc_take   = (state == TAKE);
  assign in_handler = (state == HANDLER) || (state == HALT);
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed bench for exc_sequencer: each step queues the expected post-edge outputs,
// which are popped and compared one edge later.
module tb_exc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_req;
  logic        not_an_instr;
  logic        eret;
  logic [63:0] pc_in;
  logic        exc_take;
  logic [3:0]  irq_ack;
  logic [2:0]  irq_id;
  logic [63:0] elr;
  logic [3:0]  esr;
  logic        in_handler;
  logic        halted;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        take;
    logic [3:0]  ack;
    logic [2:0]  id;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic        inh;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  exc_sequencer #(.N(64), .NIRQ(4)) dut (
    .clk(clk), .reset(reset), .irq_req(irq_req), .not_an_instr(not_an_instr),
    .eret(eret), .pc_in(pc_in), .exc_take(exc_take), .irq_ack(irq_ack),
    .irq_id(irq_id), .elr(elr), .esr(esr), .in_handler(in_handler), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // Queue the expectation, advance one edge, then pop and compare away from the edge.
  task automatic cyc(input string tag, input logic take, input logic [3:0] ack,
                     input logic [2:0] id, input logic [63:0] e_elr, input logic [3:0] e_esr,
                     input logic inh, input logic hlt);
    exp_t e;
    e = '{take: take, ack: ack, id: id, elr: e_elr, esr: e_esr, inh: inh, hlt: hlt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    total++;
    assert (sb.size() != 0)
    else begin
      bad++;
      $error("FAIL %s scoreboard: observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".exc_take"},   64'(exc_take),   64'(e.take));
      chk({tag, ".irq_ack"},    64'(irq_ack),    64'(e.ack));
      chk({tag, ".irq_id"},     64'(irq_id),     64'(e.id));
      chk({tag, ".elr"},        elr,             e.elr);
      chk({tag, ".esr"},        64'(esr),        64'(e.esr));
      chk({tag, ".in_handler"}, 64'(in_handler), 64'(e.inh));
      chk({tag, ".halted"},     64'(halted),     64'(e.hlt));
    end
  endtask

  initial begin
    reset = 1'b1; irq_req = '0; not_an_instr = 1'b0; eret = 1'b0; pc_in = '0;
    #1;
    cyc("reset", 0, 4'b0000, 3'd0, 64'h0, 4'h0, 0, 0);
    reset = 1'b0;
    cyc("idle", 0, 4'b0000, 3'd0, 64'h0, 4'h0, 0, 0);

    // IRQ entry
    irq_req = 4'b0110; pc_in = 64'h40;
    cyc("irq_take", 1, 4'b0010, 3'd1, 64'h40, 4'b0001, 0, 0);
    irq_req = 4'b0000; pc_in = 64'h44;
    cyc("irq_hdl", 0, 4'b0000, 3'd1, 64'h40, 4'b0001, 1, 0);
    eret = 1'b1;
    cyc("irq_eret", 0, 4'b0000, 3'd1, 64'h40, 4'b0001, 0, 0);
    eret = 1'b0;

    // Undefined opcode beats a simultaneous IRQ
    not_an_instr = 1'b1; irq_req = 4'b0001; pc_in = 64'h8C;
    cyc("undef_take", 1, 4'b0000, 3'd1, 64'h8C, 4'b0010, 0, 0);
    not_an_instr = 1'b0; irq_req = 4'b0000;
    cyc("undef_hdl", 0, 4'b0000, 3'd1, 64'h8C, 4'b0010, 1, 0);

    // Masked IRQ in handler, taken after ERET
    irq_req = 4'b1000; pc_in = 64'h100;
    for (int i = 0; i < 5; i++)
      cyc("mask", 0, 4'b0000, 3'd1, 64'h8C, 4'b0010, 1, 0);
    eret = 1'b1;
    cyc("mask_eret", 0, 4'b0000, 3'd1, 64'h8C, 4'b0010, 0, 0);
    eret = 1'b0; pc_in = 64'h200;
    cyc("pend_take", 1, 4'b1000, 3'd3, 64'h200, 4'b0001, 0, 0);
    irq_req = 4'b0000;
    cyc("pend_hdl", 0, 4'b0000, 3'd3, 64'h200, 4'b0001, 1, 0);

    // Double fault
    not_an_instr = 1'b1; eret = 1'b1; pc_in = 64'h300;
    cyc("dfault", 0, 4'b0000, 3'd3, 64'h200, 4'b1000, 1, 1);
    not_an_instr = 1'b0; irq_req = 4'b0001;
    for (int i = 0; i < 3; i++)
      cyc("halt_hold", 0, 4'b0000, 3'd3, 64'h200, 4'b1000, 1, 1);
    eret = 1'b0; irq_req = 4'b0000;

    // Reset during HALT, then during TAKE
    reset = 1'b1;
    cyc("rst_halt", 0, 4'b0000, 3'd0, 64'h0, 4'h0, 0, 0);
    reset = 1'b0; irq_req = 4'b0100; pc_in = 64'h500;
    cyc("take2", 1, 4'b0100, 3'd2, 64'h500, 4'b0001, 0, 0);
    reset = 1'b1; irq_req = 4'b0000;
    cyc("rst_take", 0, 4'b0000, 3'd0, 64'h0, 4'h0, 0, 0);
    reset = 1'b0;

    // Stray ERET in RUN
    eret = 1'b1; pc_in = 64'h510;
    for (int i = 0; i < 3; i++)
      cyc("stray_eret", 0, 4'b0000, 3'd0, 64'h0, 4'h0, 0, 0);
    eret = 1'b0;

    // All lines asserted: index 0 wins
    irq_req = 4'b1111; pc_in = 64'h600;
    cyc("prio0", 1, 4'b0001, 3'd0, 64'h600, 4'b0001, 0, 0);
    irq_req = 4'b0000;
    cyc("prio0_hdl", 0, 4'b0000, 3'd0, 64'h600, 4'b0001, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
